// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory port between the fetch stage (master)
// and the instruction memory (slave). A request phase (req/addr held until
// gnt) is followed by a response phase (rvalid with rdata/err).
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode. It takes decode's
// program pointer and fetches one word through the imem req/gnt + rvalid
// port, then presents it on instruction_o and stalls decode until it is
// available. A misaligned pointer or a memory error latches a sticky fault
// that only reset clears.
// Optional sequential prefetch of pc+4 is enabled by defining
// FETCH_PREFETCH_EN. Without it, at most one transaction is outstanding.
module fetch_unit #(
    parameter logic [31:0] BUBBLE    = 32'h0000_0000,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [7:0]  CORE_BOOT = 8'h01,
    parameter logic [7:0]  CORE_RUN  = 8'h02
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [7:0]   core_state_i,
    input  logic [31:0]  pc_i,
    input  logic         hold_i,
    output logic [31:0]  instruction_o,
    output logic         stall_o,
    output logic         fetch_err_o,
    fetch_unit_if.master imem
);

    // DRAIN is only reachable with the prefetcher: it waits out a prefetch
    // response that is no longer wanted (or may still match the new pc).
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        ERR,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    logic [31:0] pc_word;
    logic        run;
    logic        boot;
    logic        aligned;
    logic        demand_take;

    assign pc_word     = {pc_i[31:2], 2'b00};
    assign run         = (core_state_i == CORE_RUN);
    assign boot        = (core_state_i == CORE_BOOT);
    assign aligned     = (pc_i[1:0] == 2'b00);
    assign demand_take = (state == WAIT) && imem.rvalid && !imem.err && run;

`ifdef FETCH_PREFETCH_EN
    logic        pf_req_q;
    logic        pf_out_q;
    logic        pf_valid_q;
    logic [31:0] pf_addr_q;
    logic [31:0] pf_buf_q;
    logic        pf_granted;
    logic        pf_inflight;
    logic        pf_ready;
    logic [31:0] pf_data;
    logic        pc_mismatch;
    logic        pf_take;
    logic        pf_leave;
    logic        drain_take;
    logic        pf_start;
    logic [31:0] pf_base;

    // A word held in VALID was fetched for addr_q; if decode's pointer no
    // longer matches (taken branch after a sequential reload) it is stale.
    assign pc_mismatch = (pc_i != addr_q);
    assign pf_granted  = pf_req_q && imem.gnt;
    assign pf_inflight = pf_granted || (pf_out_q && !imem.rvalid);
    assign pf_ready    = pf_valid_q || (pf_out_q && imem.rvalid && !imem.err);
    assign pf_data     = pf_valid_q ? pf_buf_q : imem.rdata;
    assign pf_take     = (state == VALID) && !pc_mismatch && !hold_i && run && pf_ready;
    assign pf_leave    = (state == VALID) && (pc_mismatch || !hold_i) && !pf_take;
    assign drain_take  = (state == DRAIN) && imem.rvalid && !imem.err && run &&
                         (pc_i == pf_addr_q);
    assign pf_start    = demand_take || pf_take || drain_take;
    assign pf_base     = demand_take ? addr_q : pf_addr_q;

    assign imem.req  = ((state == REQ) && run && aligned) || pf_req_q;
    assign imem.addr = (state == REQ) ? pc_word : (pf_req_q ? pf_addr_q : addr_q);
`else
    assign imem.req  = (state == REQ) && run && aligned;
    assign imem.addr = (state == REQ) ? pc_word : addr_q;
`endif

    assign fetch_err_o   = (state == ERR);
    assign instruction_o = (state == VALID) ? instr_q : BUBBLE;

    // Decode is frozen unless a valid word is held, except in IDLE during
    // BOOT so decode can load its initial pointer.
    always_comb begin
        stall_o = hold_i || (state != VALID) || fetch_err_o;
`ifdef FETCH_PREFETCH_EN
        if ((state == VALID) && pc_mismatch) begin
            stall_o = 1'b1;
        end
`endif
        if ((state == IDLE) && boot) begin
            stall_o = 1'b0;
        end
    end

    // State register; reset abandons any transaction in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the fetch sequence.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (!aligned) begin
                    state_next = ERR;
                end else if (imem.gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    if (!run) begin
                        state_next = IDLE;
                    end else if (imem.err) begin
                        state_next = ERR;
                    end else begin
                        state_next = VALID;
                    end
                end
            end
            VALID: begin
`ifdef FETCH_PREFETCH_EN
                if (pc_mismatch) begin
                    state_next = pf_inflight ? DRAIN : REQ;
                end else if (!hold_i) begin
                    if (pf_take) begin
                        state_next = VALID;
                    end else if (pf_inflight) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = run ? REQ : IDLE;
                    end
                end
`else
                if (!hold_i) begin
                    state_next = run ? REQ : IDLE;
                end
`endif
            end
            ERR: begin
                state_next = ERR;
            end
`ifdef FETCH_PREFETCH_EN
            DRAIN: begin
                if (imem.rvalid) begin
                    if (drain_take) begin
                        state_next = VALID;
                    end else if (run) begin
                        state_next = REQ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Captures the granted word address and the returned instruction word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= BUBBLE;
            addr_q  <= BOOT_ADDR;
        end else begin
            if ((state == REQ) && imem.req && imem.gnt) begin
                addr_q <= pc_word;
            end
            if (demand_take) begin
                instr_q <= imem.rdata;
            end
`ifdef FETCH_PREFETCH_EN
            if (pf_take) begin
                instr_q <= pf_data;
                addr_q  <= pf_addr_q;
            end
            if (drain_take) begin
                instr_q <= imem.rdata;
                addr_q  <= pf_addr_q;
            end
`endif
        end
    end

`ifdef FETCH_PREFETCH_EN
    // Prefetch tracker: request, outstanding and filled flags for the single
    // sequential prefetch; later statements override earlier ones on purpose.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pf_req_q   <= 1'b0;
            pf_out_q   <= 1'b0;
            pf_valid_q <= 1'b0;
            pf_addr_q  <= 32'h0;
            pf_buf_q   <= 32'h0;
        end else begin
            if (pf_out_q && imem.rvalid) begin
                pf_out_q <= 1'b0;
                if (state == VALID) begin
                    pf_valid_q <= !imem.err;
                    pf_buf_q   <= imem.rdata;
                end
            end
            if (pf_granted) begin
                pf_req_q <= 1'b0;
                pf_out_q <= 1'b1;
            end
            if (pf_leave) begin
                pf_req_q   <= 1'b0;
                pf_valid_q <= 1'b0;
            end
            if (pf_start) begin
                pf_req_q   <= 1'b1;
                pf_addr_q  <= pf_base + 32'd4;
                pf_valid_q <= 1'b0;
            end
        end
    end
`endif

endmodule
